touch_poll_sequencer: RTL

Sequencer in front of the I2C touch-panel reader. It decides when a read transaction runs: on a periodic poll tick, or on a panel interrupt. It issues the 1-cycle trigger, waits for completion with a timeout, and latches the result registers. It then debounces the touch count into press/release events for the UI/counter logic.

---
 rtl/touch_poll_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/touch_poll_sequencer.sv
// touch_poll_sequencer
// Decides when the I2C touch-panel reader runs: on a periodic poll tick or on
// a falling edge of the panel interrupt. Issues a one-cycle trigger, waits
// for the reader's done edge (bounded by a timeout), latches the result
// registers and debounces the touch count into press/release events.
//
// Optional build macro: TOUCH_RANGE_CLIP_EN
//   defined   -> latched X saturates at 799, latched Y at 479 (800x480 panel)
//   undefined -> raw coordinates pass through unchanged
//
// Ports:
//   iCLK, iRSTN          clock, asynchronous active-low reset
//   iEN                  enable; low blocks new transactions from starting
//   iINT_N               panel interrupt, active-low, asynchronous
//   oTRIG                one-cycle start pulse to the reader
//   iREADY               reader done flag (pulse or level)
//   iREG_*               raw reader result registers
//   oX1/oX2/oY1/oY2      latched coordinates (held when touch count is 0)
//   oTOUCH_COUNT         latched touch count
//   oGESTURE             latched gesture code
//   oVALID               one-cycle pulse, new sample latched
//   oPRESS/oRELEASE      one-cycle debounced edge pulses
//   oTOUCHED             debounced touch level
//   oTIMEOUT             one-cycle pulse on an aborted transaction
//   oBUSY                high while in TRIG/WAIT/LATCH
module touch_poll_sequencer #(
    parameter int unsigned POLL_DIV = 500000,
    parameter int unsigned TIMEOUT  = 2000000,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       iEN,
    input  logic       iINT_N,
    output logic       oTRIG,
    input  logic       iREADY,
    input  logic [9:0] iREG_X1,
    input  logic [9:0] iREG_X2,
    input  logic [8:0] iREG_Y1,
    input  logic [8:0] iREG_Y2,
    input  logic [1:0] iREG_TOUCH_COUNT,
    input  logic [7:0] iREG_GESTURE,
    output logic [9:0] oX1,
    output logic [9:0] oX2,
    output logic [8:0] oY1,
    output logic [8:0] oY2,
    output logic [1:0] oTOUCH_COUNT,
    output logic [7:0] oGESTURE,
    output logic       oVALID,
    output logic       oPRESS,
    output logic       oRELEASE,
    output logic       oTOUCHED,
    output logic       oTIMEOUT,
    output logic       oBUSY
);

    localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRIG  = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   poll_cnt_q;
    logic [2:0]      int_sync_q;
    logic            pending_q;
    logic            rdy_prev_q;
    logic [TW-1:0]   wait_cnt_q;
    logic [DW-1:0]   db_cnt_q;

    logic            tick_c;
    logic            int_fall_c;
    logic            req_c;
    logic            launch_c;
    logic            sample_c;
    logic [9:0]      x1_c;
    logic [9:0]      x2_c;
    logic [8:0]      y1_c;
    logic [8:0]      y2_c;

    assign tick_c     = (poll_cnt_q == PW'(POLL_DIV - 1));
    // [1] is the second synchroniser stage, [2] its previous value
    assign int_fall_c = int_sync_q[2] & ~int_sync_q[1];
    assign req_c      = tick_c | int_fall_c;
    assign launch_c   = (state_q == S_IDLE) && pending_q && iEN;
    assign sample_c   = |iREG_TOUCH_COUNT;

`ifdef TOUCH_RANGE_CLIP_EN
    localparam logic [9:0] X_MAX = 10'd799;
    localparam logic [8:0] Y_MAX = 9'd479;

    // Saturate to the visible panel area
    assign x1_c = (iREG_X1 > X_MAX) ? X_MAX : iREG_X1;
    assign x2_c = (iREG_X2 > X_MAX) ? X_MAX : iREG_X2;
    assign y1_c = (iREG_Y1 > Y_MAX) ? Y_MAX : iREG_Y1;
    assign y2_c = (iREG_Y2 > Y_MAX) ? Y_MAX : iREG_Y2;
`else
    assign x1_c = iREG_X1;
    assign x2_c = iREG_X2;
    assign y1_c = iREG_Y1;
    assign y2_c = iREG_Y2;
`endif

    // Free-running poll divider, independent of iEN
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            poll_cnt_q <= '0;
        end else if (tick_c) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_q + PW'(1);
        end
    end

    // Interrupt synchroniser; resets to the idle (high) level so reset
    // release cannot fake a falling edge
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            int_sync_q <= 3'b111;
        end else begin
            int_sync_q <= {int_sync_q[1:0], iINT_N};
        end
    end

    // Single-depth request flag; a request arriving as the flag is consumed
    // coalesces into the transaction being launched
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            pending_q <= 1'b0;
        end else if (launch_c) begin
            pending_q <= 1'b0;
        end else if (req_c) begin
            pending_q <= 1'b1;
        end
    end

    // Transaction FSM with registered outputs
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q      <= S_IDLE;
            rdy_prev_q   <= 1'b0;
            wait_cnt_q   <= '0;
            db_cnt_q     <= '0;
            oTRIG        <= 1'b0;
            oX1          <= '0;
            oX2          <= '0;
            oY1          <= '0;
            oY2          <= '0;
            oTOUCH_COUNT <= '0;
            oGESTURE     <= '0;
            oVALID       <= 1'b0;
            oPRESS       <= 1'b0;
            oRELEASE     <= 1'b0;
            oTOUCHED     <= 1'b0;
            oTIMEOUT     <= 1'b0;
            oBUSY        <= 1'b0;
        end else begin
            oTRIG    <= 1'b0;
            oVALID   <= 1'b0;
            oPRESS   <= 1'b0;
            oRELEASE <= 1'b0;
            oTIMEOUT <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (launch_c) begin
                        state_q <= S_TRIG;
                        oTRIG   <= 1'b1;
                        oBUSY   <= 1'b1;
                    end
                end

                S_TRIG: begin
                    rdy_prev_q <= iREADY;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end

                S_WAIT: begin
                    rdy_prev_q <= iREADY;
                    // Require a 0->1 seen inside WAIT so a reader that still
                    // holds a stale level high is not mistaken for done
                    if (!rdy_prev_q && iREADY) begin
                        state_q <= S_LATCH;
                    end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        oTIMEOUT <= 1'b1;
                        oBUSY    <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
                end

                S_LATCH: begin
                    oTOUCH_COUNT <= iREG_TOUCH_COUNT;
                    oGESTURE     <= iREG_GESTURE;
                    // No touch: keep the last known coordinates
                    if (sample_c) begin
                        oX1 <= x1_c;
                        oX2 <= x2_c;
                        oY1 <= y1_c;
                        oY2 <= y2_c;
                    end
                    if (sample_c != oTOUCHED) begin
                        if (db_cnt_q == DW'(DEBOUNCE - 1)) begin
                            oTOUCHED <= sample_c;
                            db_cnt_q <= '0;
                            oPRESS   <= sample_c;
                            oRELEASE <= ~sample_c;
                        end else begin
                            db_cnt_q <= db_cnt_q + DW'(1);
                        end
                    end else begin
                        db_cnt_q <= '0;
                    end
                    oVALID  <= 1'b1;
                    oBUSY   <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    oBUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule
